// File: rtl/dmem_responder_if.sv
// Data-bus interface between the RV32 core MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        ena_rd;
    logic        ena_wr;
    logic [31:0] alu_out_ext;
    logic [31:0] dataram_wr;
    logic [31:0] dataram_rd;

    modport master (
        output ena_rd,
        output ena_wr,
        output alu_out_ext,
        output dataram_wr,
        input  dataram_rd
    );

    modport slave (
        input  ena_rd,
        input  ena_wr,
        input  alu_out_ext,
        input  dataram_wr,
        output dataram_rd
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus GPIO / cycle counter / timer / status register window.
// Define DMEM_TIMER_EN to build the TIMER_CMP register, STATUS bit0 and irq_timer.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
    parameter logic [63:0] CNT_INIT   = '0
) (
    input  logic            CLOCK,
    input  logic            RST,
    dmem_responder_if.slave bus,
    output logic [31:0]     gpio_out,
    output logic            irq_timer,
    output logic            err_misaligned
);

    localparam int unsigned WORDS     = 2 ** DEPTH_LOG2;
    localparam logic [31:0] RAM_BYTES = 32'(4 * WORDS);
    localparam logic [31:0] WIN_BYTES = 32'h0000_0020;

    typedef enum logic [2:0] {
        REG_GPIO      = 3'd0,
        REG_CYCLE_LO  = 3'd1,
        REG_HI_SNAP   = 3'd2,
        REG_TIMER_CMP = 3'd3,
        REG_STATUS    = 3'd4
    } reg_sel_e;

    logic [31:0]           mem [WORDS];
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] word_idx;
    reg_sel_e              reg_sel;

    logic access;
    logic misaligned;
    logic ram_hit;
    logic mmio_hit;
    logic rd_ok;
    logic wr_ok;
    logic wr_ram;
    logic wr_gpio;
    logic wr_status;
    logic snap_hi;

    logic [63:0] cnt;
    logic [31:0] hi_snap;
    logic [31:0] gpio_q;
    logic        err_q;
    logic [31:0] timer_cmp;
    logic        timer_pend;
    logic [31:0] rd_data;

    // Address decode; RAM takes priority should the window ever overlap it.
    assign addr       = bus.alu_out_ext;
    assign wdata      = bus.dataram_wr;
    assign off        = addr - MMIO_BASE;
    assign word_idx   = addr[DEPTH_LOG2+1:2];
    assign reg_sel    = reg_sel_e'(off[4:2]);
    assign access     = bus.ena_rd | bus.ena_wr;
    assign misaligned = access && (addr[1:0] != 2'b00);
    assign ram_hit    = addr < RAM_BYTES;
    assign mmio_hit   = !ram_hit && (addr >= MMIO_BASE) && (off < WIN_BYTES);
    assign rd_ok      = bus.ena_rd && !misaligned;
    assign wr_ok      = bus.ena_wr && !misaligned;
    assign wr_ram     = wr_ok && ram_hit;
    assign wr_gpio    = wr_ok && mmio_hit && (reg_sel == REG_GPIO);
    assign wr_status  = wr_ok && mmio_hit && (reg_sel == REG_STATUS);
    assign snap_hi    = rd_ok && mmio_hit && (reg_sel == REG_CYCLE_LO);

    // RAM is never cleared, but a write landing while RST is high is dropped.
    always_ff @(posedge CLOCK or posedge RST) begin
        if (!RST && wr_ram) begin
            mem[word_idx] <= wdata;
        end
    end

    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            cnt     <= CNT_INIT;
            hi_snap <= '0;
            gpio_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt <= cnt + 64'd1;
            if (snap_hi) begin
                hi_snap <= cnt[63:32];
            end
            if (wr_gpio) begin
                gpio_q <= wdata;
            end
            // A new misalignment outranks a simultaneous W1C.
            err_q <= misaligned | (err_q & ~(wr_status & wdata[1]));
        end
    end

`ifdef DMEM_TIMER_EN
    logic wr_tcmp;
    logic timer_hit;

    assign wr_tcmp   = wr_ok && mmio_hit && (reg_sel == REG_TIMER_CMP);
    assign timer_hit = (cnt[31:0] == timer_cmp) && (timer_cmp != '0);

    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            timer_cmp  <= '0;
            timer_pend <= 1'b0;
        end else begin
            if (wr_tcmp) begin
                timer_cmp <= wdata;
            end
            timer_pend <= timer_hit | (timer_pend & ~(wr_status & wdata[0]));
        end
    end
`else
    assign timer_cmp  = '0;
    assign timer_pend = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        if (rd_ok) begin
            if (ram_hit) begin
                rd_data = mem[word_idx];
            end else if (mmio_hit) begin
                case (reg_sel)
                    REG_GPIO:      rd_data = gpio_q;
                    REG_CYCLE_LO:  rd_data = cnt[31:0];
                    REG_HI_SNAP:   rd_data = hi_snap;
                    REG_TIMER_CMP: rd_data = timer_cmp;
                    REG_STATUS:    rd_data = {30'b0, err_q, timer_pend};
                    default:       rd_data = '0;
                endcase
            end
        end
    end

    assign bus.dataram_rd = rd_data;
    assign gpio_out       = gpio_q;
    assign irq_timer      = timer_pend;
    assign err_misaligned = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table for the single-cycle behaviour plus timer, reset and counter-wrap sequences.
module tb_dmem_responder;

    localparam logic [31:0] A_GPIO   = 32'h8000_0000;
    localparam logic [31:0] A_CYC_LO = 32'h8000_0004;
    localparam logic [31:0] A_HI     = 32'h8000_0008;
    localparam logic [31:0] A_TCMP   = 32'h8000_000C;
    localparam logic [31:0] A_STATUS = 32'h8000_0010;
    localparam int          NVEC     = 35;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [31:0] exp_gpio;
        logic        exp_err;
    } vec_t;

    logic        CLOCK = 1'b0;
    logic        RST   = 1'b1;
    logic [31:0] gpio_out;
    logic        irq_timer;
    logic        err_misaligned;
    logic [31:0] gpio_w;
    logic        irq_w;
    logic        err_w;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    vec_t vecs [NVEC];

    dmem_responder_if bus ();
    dmem_responder_if bus_w ();

    always #5 CLOCK = ~CLOCK;

    dmem_responder dut (
        .CLOCK          (CLOCK),
        .RST            (RST),
        .bus            (bus),
        .gpio_out       (gpio_out),
        .irq_timer      (irq_timer),
        .err_misaligned (err_misaligned)
    );

    // Counter preloaded just below the 32-bit carry so the HI_SNAP rollover is reachable.
    dmem_responder #(.CNT_INIT(64'h0000_0001_FFFF_FFFE)) dut_w (
        .CLOCK          (CLOCK),
        .RST            (RST),
        .bus            (bus_w),
        .gpio_out       (gpio_w),
        .irq_timer      (irq_w),
        .err_misaligned (err_w)
    );

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.ena_rd      = rd;
        bus.ena_wr      = wr;
        bus.alu_out_ext = a;
        bus.dataram_wr  = d;
    endtask

    task automatic drive_w(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus_w.ena_rd      = rd;
        bus_w.ena_wr      = wr;
        bus_w.alu_out_ext = a;
        bus_w.dataram_wr  = d;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rd    wr    addr          wdata         exp_rd        exp_gpio      err
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, A_CYC_LO,      32'h0,        32'h1,        32'h0,        1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h0,        32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h55,       32'h0,        32'h0,        1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,        32'h0,        32'h0,        1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1,        32'h0,        32'h0,        1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h2,        32'h1,        32'h0,        1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        32'h2,        32'h0,        1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0006, 32'h1234,     32'h0,        32'h0,        1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0006, 32'h0,        32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        32'h55,       32'h0,        1'b1};
        vecs[13] = '{1'b1, 1'b0, A_STATUS,      32'h0,        32'h2,        32'h0,        1'b1};
        vecs[14] = '{1'b0, 1'b1, A_STATUS,      32'h2,        32'h0,        32'h0,        1'b1};
        vecs[15] = '{1'b1, 1'b0, A_STATUS,      32'h0,        32'h0,        32'h0,        1'b0};
        vecs[16] = '{1'b0, 1'b1, A_GPIO,        32'hCAFEF00D, 32'h0,        32'h0,        1'b0};
        vecs[17] = '{1'b1, 1'b0, A_GPIO,        32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vecs[18] = '{1'b1, 1'b0, A_CYC_LO,      32'h0,        32'd18,       32'hCAFEF00D, 1'b0};
        vecs[19] = '{1'b1, 1'b0, A_HI,          32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 32'h4000_0000, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 32'h4000_0000, 32'hFFFFFFFF, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h13579BDF, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,        32'h13579BDF, 32'hCAFEF00D, 1'b0};
        vecs[24] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
        vecs[25] = '{1'b1, 1'b0, 32'h8000_0020, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
        vecs[26] = '{1'b0, 1'b0, A_GPIO,        32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
        vecs[27] = '{1'b1, 1'b0, A_TCMP,        32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
        vecs[28] = '{1'b1, 1'b0, 32'h8000_0014, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
        vecs[29] = '{1'b0, 1'b1, 32'h8000_0012, 32'hFFFFFFFF, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[30] = '{1'b1, 1'b0, A_STATUS,      32'h0,        32'h2,        32'hCAFEF00D, 1'b1};
        vecs[31] = '{1'b0, 1'b1, A_STATUS,      32'h1,        32'h0,        32'hCAFEF00D, 1'b1};
        vecs[32] = '{1'b1, 1'b0, A_STATUS,      32'h0,        32'h2,        32'hCAFEF00D, 1'b1};
        vecs[33] = '{1'b0, 1'b1, A_STATUS,      32'h2,        32'h0,        32'hCAFEF00D, 1'b1};
        vecs[34] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0};

        drive(1'b0, 1'b0, '0, '0);
        drive_w(1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge CLOCK);
        #1;
        check("reset_gpio", gpio_out, 32'h0);
        check("reset_irq", {31'b0, irq_timer}, 32'h0);
        check("reset_err", {31'b0, err_misaligned}, 32'h0);
        check("reset_rd", bus.dataram_rd, 32'h0);

        @(negedge CLOCK);
        RST = 1'b0;
        cyc = 0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #1;
            check($sformatf("vec%0d_rd", i), bus.dataram_rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_gpio", i), gpio_out, vecs[i].exp_gpio);
            check($sformatf("vec%0d_err", i), {31'b0, err_misaligned}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_irq", i), {31'b0, irq_timer}, 32'h0);
            tick();
        end

`ifdef DMEM_TIMER_EN
        drive(1'b0, 1'b1, A_TCMP, 32'd50);
        tick();
        drive(1'b1, 1'b0, A_TCMP, '0);
        #1 check("tcmp_readback", bus.dataram_rd, 32'd50);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        while (cyc < 50) tick();
        drive(1'b1, 1'b0, A_CYC_LO, '0);
        #1;
        check("cycle_at_match", bus.dataram_rd, 32'd50);
        check("irq_before_match", {31'b0, irq_timer}, 32'h0);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        #1 check("irq_rise", {31'b0, irq_timer}, 32'h1);
        repeat (3) tick();
        drive(1'b1, 1'b0, A_STATUS, '0);
        #1;
        check("status_pending", bus.dataram_rd, 32'h1);
        check("irq_sticky", {31'b0, irq_timer}, 32'h1);
        drive(1'b0, 1'b1, A_TCMP, 32'(cyc + 3));
        tick();
        drive(1'b0, 1'b1, A_STATUS, 32'h1);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        #1 check("irq_cleared", {31'b0, irq_timer}, 32'h0);
        tick();
        drive(1'b0, 1'b1, A_STATUS, 32'h1);
        #1 check("irq_before_second", {31'b0, irq_timer}, 32'h0);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        #1 check("irq_set_beats_clear", {31'b0, irq_timer}, 32'h1);
        tick();
`else
        drive(1'b0, 1'b1, A_TCMP, 32'd50);
        tick();
        drive(1'b1, 1'b0, A_TCMP, '0);
        #1 check("tcmp_reads_zero", bus.dataram_rd, 32'h0);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        while (cyc < 53) tick();
        #1 check("irq_tied_low", {31'b0, irq_timer}, 32'h0);
        drive(1'b1, 1'b0, A_STATUS, '0);
        #1 check("status_no_pending", bus.dataram_rd, 32'h0);
        tick();
`endif

        drive(1'b0, 1'b1, A_GPIO, 32'hA5);
        tick();
        drive(1'b0, 1'b1, 32'h0000_0030, 32'h2222);
        #1 check("gpio_a5", gpio_out, 32'hA5);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0001, '0);
        tick();
        drive(1'b0, 1'b1, 32'h0000_0030, 32'h1111);
        #1 check("err_before_reset", {31'b0, err_misaligned}, 32'h1);
        RST = 1'b1;
        #1;
        check("midreset_gpio", gpio_out, 32'h0);
        check("midreset_err", {31'b0, err_misaligned}, 32'h0);
        check("midreset_irq", {31'b0, irq_timer}, 32'h0);
        drive(1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge CLOCK);
        RST = 1'b0;
        cyc = 0;

        drive(1'b1, 1'b0, 32'h0000_0030, '0);
        drive_w(1'b1, 1'b0, A_HI, '0);
        #1;
        check("ram_survives_reset", bus.dataram_rd, 32'h2222);
        check("wrap_hi_reset", bus_w.dataram_rd, 32'h0);
        tick();
        drive(1'b1, 1'b0, A_CYC_LO, '0);
        drive_w(1'b1, 1'b0, A_CYC_LO, '0);
        #1;
        check("cycle_after_reset", bus.dataram_rd, 32'h1);
        check("wrap_lo_max", bus_w.dataram_rd, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0010, '0);
        drive_w(1'b1, 1'b0, A_HI, '0);
        #1;
        check("ram_word_kept", bus.dataram_rd, 32'hDEADBEEF);
        check("wrap_hi_snap", bus_w.dataram_rd, 32'h1);
        tick();
        drive(1'b1, 1'b0, A_GPIO, '0);
        drive_w(1'b1, 1'b0, A_CYC_LO, '0);
        #1;
        check("gpio_read_after_reset", bus.dataram_rd, 32'h0);
        check("wrap_lo_rolled", bus_w.dataram_rd, 32'h1);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        drive_w(1'b1, 1'b0, A_HI, '0);
        #1 check("wrap_hi_rolled", bus_w.dataram_rd, 32'h2);
        tick();
        drive_w(1'b0, 1'b0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RV32 core: the target end of the core's data-bus interface (`ena_rd`, `ena_wr`, `alu_out_ext`, `dataram_wr`, `dataram_rd`). It holds a word-addressed RAM and a small memory-mapped register window containing a GPIO output register, a 64-bit cycle counter, a compare timer and sticky error/status flags. Reads complete in the same cycle, which the core's MEM-stage bypass requires. Writes commit on the clock edge.

## Interface
- `DEPTH_LOG2`, 10: RAM holds 2^DEPTH_LOG2 32-bit words at byte addresses 0 to 4·2^DEPTH_LOG2−1.
- `MMIO_BASE`, 32'h8000_0000: base byte address of the register window (window spans 0x20 bytes).
- `CLOCK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `ena_rd` in 1: read strobe from the core's MEM stage.
- `ena_wr` in 1: write strobe from the core's MEM stage.
- `alu_out_ext` in 32: byte address.
- `dataram_wr` in 32: write data.
- `dataram_rd` out 32: read data, combinational.
- `gpio_out` out 32: GPIO_OUT register.
- `irq_timer` out 1: timer-pending flag.
- `err_misaligned` out 1: sticky misalignment flag.

## Operation
- **Decode:**
  - RAM hit: `alu_out_ext < 4·2^DEPTH_LOG2`.
  - MMIO hit: `MMIO_BASE <= alu_out_ext < MMIO_BASE+0x20`.
  - Anything else is unmapped.
- **Misaligned access:** `alu_out_ext[1:0] != 0` while `ena_rd` or `ena_wr` is high.
  - The write is suppressed and the read returns 0.
  - `err_misaligned` is set at the next edge.
- **Register map (offset from MMIO_BASE):**
  - +0x00 GPIO_OUT: RW.
  - +0x04 CYCLE_LO: RO. Returns `cnt[31:0]`. Reading it latches `cnt[63:32]` of the same cycle into HI_SNAP at the edge.
  - +0x08 HI_SNAP: RO.
  - +0x0C TIMER_CMP: RW.
  - +0x10 STATUS: bit0 = timer pending, bit1 = misaligned error. Write-1-to-clear. Other bits read 0.
  - +0x14 to +0x1C: read 0, writes ignored.
- **Unmapped addresses:** reads return 0 and writes are ignored.
- **Read data rule:** `dataram_rd = 0` whenever `ena_rd` is low. There is no dependence on stale state.
- **Cycle counter:**
  - 64-bit, increments every edge while `RST` is low, wraps at 2^64 to 0.
  - The value in the Nth cycle after reset release is N−1 (0 in the first cycle).
- **Timer:**
  - At an edge where `cnt[31:0] == TIMER_CMP` and `TIMER_CMP != 0`, pending is set.
  - Pending stays set until it is cleared by writing 1 to STATUS bit0.
  - If a set and a clear occur in the same edge, the set wins.
- **Misaligned flag:** a misalignment event and a W1C of bit1 in the same edge leaves the flag set.
- **Simultaneous `ena_rd` and `ena_wr`:** the write commits at the edge. `dataram_rd` shows the pre-write contents during that cycle.
- **RAM contents:** not reset (undefined until written).

## Timing
- Read latency is 0 cycles: `dataram_rd` is combinational from `alu_out_ext` and `ena_rd`, and valid in the same cycle.
- Write latency is 1 edge: data is visible to a read in the following cycle.
- **Reset values:**
  - `dataram_rd` = 0 (since `ena_rd` is low).
  - `gpio_out` = 0.
  - `irq_timer` = 0.
  - `err_misaligned` = 0.
  - Counter, HI_SNAP and TIMER_CMP = 0.
- Asserting `RST` mid-operation clears all registers immediately. The RAM is untouched and any in-flight write is dropped.
- Status outputs (`irq_timer`, `err_misaligned`) change only on a rising edge or on reset.

## Configuration
- `DMEM_TIMER_EN` defined: the TIMER_CMP register, STATUS bit0 and `irq_timer` logic are present as described above.
- `DMEM_TIMER_EN` undefined:
  - TIMER_CMP reads 0 and writes to it are ignored.
  - STATUS bit0 reads 0.
  - `irq_timer` is tied to 0.
  - The cycle counter, GPIO and misaligned error are unaffected.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010. Next cycle, read 0x10 → `dataram_rd` = 0xDEADBEEF. Read 0x14 (unwritten after a prior write of 0) → 0.
- `ena_rd` and `ena_wr` both high to 0x20 holding 0x1, writing 0x2 → same-cycle read = 0x1. Next cycle's read = 0x2.
- Write 0x1234 to address 0x0000_0006 → no RAM change, `err_misaligned` = 1 after the edge, read returns 0. Write 0x2 to STATUS → flag clears.
- Read CYCLE_LO at counter value 0x0000_0001_FFFF_FFFF → `dataram_rd` = 0xFFFF_FFFF. Next cycle, HI_SNAP reads 0x1 while the live counter has rolled to 0x0000_0002_0000_0000.
- With `DMEM_TIMER_EN`: write TIMER_CMP = 50 → `irq_timer` rises at the edge where `cnt` = 50 and stays high. Write 0x1 to STATUS in the same cycle as a second match → `irq_timer` remains 1.
- Assert `RST` mid-burst after writing GPIO_OUT = 0xA5 → `gpio_out` = 0 immediately. The previously written RAM word is still readable after reset release.
